if_id_reg: RTL and testbench
============================

// Module: if_id_reg
// PURPOSE
//  IF/ID pipeline register with a 2-entry skid buffer between instruction fetch and decode.
//  - Captures {pc, instr} from IF and presents them to ID, together with the split instruction fields.
//  - Emits id_imm_sign, a registered select. The ID stage uses it to choose between the sign-extended
//    and zero-extended versions of id_imm16, both produced by extend instances.
//  - Supports backpressure (id_ready) and pipeline flush (branch/exception redirect).
// PARAMETERS
//  PC_BITS     32  width of program counter
//  INSTR_BITS  32  width of instruction word (fixed MIPS32 field layout; must be 32)
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        synchronous reset, active-high
//  if_valid      in   1        IF presents a valid instruction
//  if_ready      out  1        register can accept (registered: skid entry empty)
//  if_pc         in   PC_BITS  PC of fetched instruction
//  if_instr      in   32       fetched instruction word
//  flush         in   1        discard all buffered instructions
//  id_ready      in   1        ID consumes current output this cycle
//  id_valid      out  1        main entry holds a valid instruction
//  id_pc         out  PC_BITS  PC of presented instruction
//  id_instr      out  32       presented instruction
//  id_op         out  6        instr[31:26]
//  id_rs         out  5        instr[25:21]
//  id_rt         out  5        instr[20:16]
//  id_rd         out  5        instr[15:11]
//  id_shamt      out  5        instr[10:6]
//  id_funct      out  6        instr[5:0]
//  id_imm16      out  16       instr[15:0], fed to extend
//  id_imm_sign   out  1        1 = sign-extend imm16; 0 = zero-extend
// BEHAVIOUR
//  - Reset: all outputs are 0 after the first clk edge with rst=1, with one exception:
//    if_ready is 1.
//  - Storage: a main entry drives the id_* outputs; a skid entry holds overflow.
//    if_ready = !skid_valid, and it is a registered signal.
//  - Handshakes: accept = if_valid & if_ready; take = id_valid & id_ready.
//  - Latency: an instruction accepted into an empty register appears on id_* the next cycle.
//  - Next-state rules, in priority order:
//    1. rst or flush: main and skid valid are cleared and their payload is cleared to 0
//       (instr 0 = sll nop). An instruction accepted in the same cycle is dropped.
//    2. main empty, or take: main <- skid if skid is valid, otherwise main <- incoming
//       if accept, otherwise main becomes empty. If skid was moved into main and accept
//       is also set, skid <- incoming.
//    3. main full, no take, accept: skid <- incoming, and if_ready drops to 0 next cycle.
//  - Ordering: instructions leave in strict FIFO order. Nothing is duplicated or lost
//    except on flush.
//  - Field outputs and id_imm_sign are registered with the entry and are
//    glitch-free off clk.
//  - id_imm_sign is decoded from op at capture time:
//    - 1 for 000001 (regimm), 0001xx (beq/bne/blez/bgtz), 001000-001011 (addi/addiu/slti/sltiu),
//      and 100xxx/101xxx (loads/stores).
//    - 0 for 001100-001111 (andi/ori/xori/lui) and for all other opcodes.
//  - Payload is unchanged while id_valid & !id_ready (stall holds).
//  - flush & take in the same cycle: ID owns the taken instruction; the register is empty
//    next cycle.
// TESTING
//  1. Reset, then stream addi(0x2008FFFF) @pc 0xBFC00000 with id_ready=1.
//     Expect next cycle: id_valid=1, id_op=0x08, id_rt=8, id_imm16=0xFFFF, id_imm_sign=1.
//  2. ori 0x3508_8000 -> id_imm_sign=0, id_imm16=0x8000. lui 0x3C01_1234 -> id_imm_sign=0.
//  3. Hold id_ready=0 while IF streams I0,I1,I2:
//     I0 is in main, I1 in skid, if_ready=0, and I2 is held at IF.
//     Then release id_ready: output order is I0,I1,I2 on consecutive cycles.
//  4. Both entries full, then assert flush for 1 cycle with if_valid=1.
//     Next cycle: id_valid=0, id_instr=0, if_ready=1; the flushed and incoming
//     instructions never appear.
//  5. Assert rst mid-stream with skid full.
//     Next cycle: id_valid=0, all fields 0, if_ready=1.
//     The first post-reset instruction appears with 1-cycle latency.
//  6. Random if_valid/id_ready for 10k cycles against a FIFO scoreboard:
//     no loss, no duplication, order preserved.

Source files
------------

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline register with a 2-entry skid buffer, MIPS32 field
//            split and registered immediate sign-extension select.
// Revision : 1.0
// ============================================================================
module if_id_reg #(
    parameter int PC_BITS    = 32,
    parameter int INSTR_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [PC_BITS-1:0]    if_pc,
    input  logic [INSTR_BITS-1:0] if_instr,
    input  logic                  flush,
    input  logic                  id_ready,
    output logic                  id_valid,
    output logic [PC_BITS-1:0]    id_pc,
    output logic [INSTR_BITS-1:0] id_instr,
    output logic [5:0]            id_op,
    output logic [4:0]            id_rs,
    output logic [4:0]            id_rt,
    output logic [4:0]            id_rd,
    output logic [4:0]            id_shamt,
    output logic [5:0]            id_funct,
    output logic [15:0]           id_imm16,
    output logic                  id_imm_sign
);

    logic                  main_valid_q, main_valid_d;
    logic [PC_BITS-1:0]    main_pc_q,    main_pc_d;
    logic [INSTR_BITS-1:0] main_instr_q, main_instr_d;
    logic                  main_sign_q,  main_sign_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [PC_BITS-1:0]    skid_pc_q,    skid_pc_d;
    logic [INSTR_BITS-1:0] skid_instr_q, skid_instr_d;
    logic                  if_ready_q,   if_ready_d;

    logic accept;
    logic take;

    // Sign-extended immediates: regimm, branches, arithmetic/compare immediates, loads/stores.
    function automatic logic imm_sign_dec(input logic [5:0] op);
        return (op == 6'b000001) || (op[5:2] == 4'b0001) ||
               (op[5:2] == 4'b0010) || (op[5:4] == 2'b10);
    endfunction

    assign accept = if_valid & if_ready_q;
    assign take   = main_valid_q & id_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_pc_d    = '0;
            main_instr_d = '0;
            skid_valid_d = 1'b0;
            skid_pc_d    = '0;
            skid_instr_d = '0;
        end else if (!main_valid_q || take) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_pc_d    = skid_pc_q;
                main_instr_d = skid_instr_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_pc_d    = if_pc;
                    skid_instr_d = if_instr;
                end
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_pc_d    = if_pc;
                main_instr_d = if_instr;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = if_pc;
            skid_instr_d = if_instr;
        end

        main_sign_d = imm_sign_dec(main_instr_d[31:26]);
        if_ready_d  = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_pc_q    <= '0;
            main_instr_q <= '0;
            main_sign_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            if_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            main_sign_q  <= main_sign_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            if_ready_q   <= if_ready_d;
        end
    end

    assign if_ready    = if_ready_q;
    assign id_valid    = main_valid_q;
    assign id_pc       = main_pc_q;
    assign id_instr    = main_instr_q;
    assign id_op       = main_instr_q[31:26];
    assign id_rs       = main_instr_q[25:21];
    assign id_rt       = main_instr_q[20:16];
    assign id_rd       = main_instr_q[15:11];
    assign id_shamt    = main_instr_q[10:6];
    assign id_funct    = main_instr_q[5:0];
    assign id_imm16    = main_instr_q[15:0];
    assign id_imm_sign = main_sign_q;

endmodule
`default_nettype wire

// File: tb/tb_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_reg
// Purpose  : Scoreboard bench for if_id_reg: directed scenarios plus random
//            valid/ready/flush/reset traffic against a FIFO reference model.
// Revision : 1.0
// ============================================================================
module tb_if_id_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [5:0]  id_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm16;
    logic        id_imm_sign;

    always #5 clk = ~clk;

    if_id_reg #(.PC_BITS(32), .INSTR_BITS(32)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .flush(flush), .id_ready(id_ready), .id_valid(id_valid),
        .id_pc(id_pc), .id_instr(id_instr), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_shamt(id_shamt), .id_funct(id_funct), .id_imm16(id_imm16),
        .id_imm_sign(id_imm_sign)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;

    function automatic bit sign_ref(input int op);
        return (op == 1) || (op >= 4 && op <= 11) || (op >= 32 && op <= 47);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the model queue front is what ID must see; a take retires it.
    always @(negedge clk) begin
        if (chk_en) begin
            check("id_valid", {31'b0, id_valid}, {31'b0, sb.size() > 0});
            check("if_ready", {31'b0, if_ready}, {31'b0, sb.size() < 2});
            if (sb.size() > 0) begin
                ent_t e;
                e = sb[0];
                check("id_pc",    id_pc,    e.pc);
                check("id_instr", id_instr, e.ins);
                check("id_op",    {26'b0, id_op},    (e.ins >> 26) & 32'h3f);
                check("id_rs",    {27'b0, id_rs},    (e.ins >> 21) & 32'h1f);
                check("id_rt",    {27'b0, id_rt},    (e.ins >> 16) & 32'h1f);
                check("id_rd",    {27'b0, id_rd},    (e.ins >> 11) & 32'h1f);
                check("id_shamt", {27'b0, id_shamt}, (e.ins >> 6) & 32'h1f);
                check("id_funct", {26'b0, id_funct}, e.ins & 32'h3f);
                check("id_imm16", {16'b0, id_imm16}, e.ins & 32'hffff);
                check("id_imm_sign", {31'b0, id_imm_sign},
                      {31'b0, sign_ref(int'(e.ins >> 26))});
                if (id_ready) void'(sb.pop_front());
            end
        end
    end

    // Drive one cycle of inputs; model accept from the pre-edge occupancy.
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit rdy, input bit fl, input bit r);
        bit acc;
        if_valid = v; if_instr = ins; if_pc = pc;
        id_ready = rdy; flush = fl; rst = r;
        acc = v && (sb.size() < 2);
        @(posedge clk);
        #1;
        if (r || fl) sb.delete();
        else if (acc) sb.push_back('{pc: pc, ins: ins});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] pc;
        rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0;
        flush = 1'b0; id_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_id_valid", {31'b0, id_valid}, 32'd0);
        check("rst_if_ready", {31'b0, if_ready}, 32'd1);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_imm_sign", {31'b0, id_imm_sign}, 32'd0);
        chk_en = 1'b1;

        // addi / ori / lui
        step(1'b1, 32'h2008FFFF, 32'hBFC00000, 1'b1, 1'b0, 1'b0);
        check("addi_valid", {31'b0, id_valid}, 32'd1);
        check("addi_op", {26'b0, id_op}, 32'h08);
        check("addi_rt", {27'b0, id_rt}, 32'd8);
        check("addi_imm", {16'b0, id_imm16}, 32'hFFFF);
        check("addi_sign", {31'b0, id_imm_sign}, 32'd1);
        step(1'b1, 32'h35088000, 32'hBFC00004, 1'b1, 1'b0, 1'b0);
        check("ori_sign", {31'b0, id_imm_sign}, 32'd0);
        check("ori_imm", {16'b0, id_imm16}, 32'h8000);
        step(1'b1, 32'h3C011234, 32'hBFC00008, 1'b1, 1'b0, 1'b0);
        check("lui_sign", {31'b0, id_imm_sign}, 32'd0);
        idle(2);

        // Backpressure: I0 main, I1 skid, I2 held at IF
        step(1'b1, 32'h8C010000, 32'h100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h8C020004, 32'h104, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h8C030008, 32'h108, 1'b0, 1'b0, 1'b0);
        check("bp_if_ready", {31'b0, if_ready}, 32'd0);
        check("bp_main", id_instr, 32'h8C010000);
        step(1'b1, 32'h8C030008, 32'h108, 1'b1, 1'b0, 1'b0);
        check("bp_rel1", id_instr, 32'h8C020004);
        step(1'b1, 32'h8C030008, 32'h108, 1'b1, 1'b0, 1'b0);
        check("bp_rel2", id_instr, 32'h8C030008);
        idle(2);

        // Flush with both entries full and a new instruction offered
        step(1'b1, 32'h10220003, 32'h200, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h14220003, 32'h204, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h24420001, 32'h208, 1'b0, 1'b1, 1'b0);
        check("fl_valid", {31'b0, id_valid}, 32'd0);
        check("fl_instr", id_instr, 32'd0);
        check("fl_if_ready", {31'b0, if_ready}, 32'd1);
        idle(2);

        // Reset mid-stream with skid full
        step(1'b1, 32'hAC010000, 32'h300, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hAC020004, 32'h304, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hAC030008, 32'h308, 1'b1, 1'b0, 1'b1);
        check("mr_valid", {31'b0, id_valid}, 32'd0);
        check("mr_instr", id_instr, 32'd0);
        check("mr_pc", id_pc, 32'd0);
        check("mr_if_ready", {31'b0, if_ready}, 32'd1);
        step(1'b1, 32'h04110010, 32'h400, 1'b0, 1'b0, 1'b0);
        check("mr_first", id_instr, 32'h04110010);
        check("mr_first_sign", {31'b0, id_imm_sign}, 32'd1);
        idle(2);

        // Random traffic
        pc = 32'h1000;
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            step(($urandom % 4) != 0, ins, pc, ($urandom % 3) != 0,
                 ($urandom % 97) == 0, ($urandom % 1009) == 0);
            pc = pc + 32'd4;
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
